// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: load/store funct3 sizes, opcodes, and the memory
// port arbiter's state encoding.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Encodings with no load/store meaning; stores have no unsigned variants.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for one 32-bit bus word: byte enables, store lane
// replication, load extraction/extension and the natural-alignment check.
module mem_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] shifted;

  assign shifted = mem_rdata >> {addr_lo, 3'b000};

  always_comb begin
    be       = 4'b0000;
    misalign = 1'b0;
    case (funct3[1:0])
      2'b00: be = 4'b0001 << addr_lo;
      2'b01: begin
        be       = 4'b0011 << addr_lo;
        misalign = addr_lo[0];
      end
      2'b10: begin
        be       = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: be = 4'b0000;
    endcase
  end

  // Each lane carries the store byte that would land there at any legal offset.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_rep[8*gi +: 8] = (funct3[1:0] == 2'b00) ? wdata[7:0] :
                                  (funct3[1:0] == 2'b01) ? wdata[8*(gi%2) +: 8] :
                                                           wdata[8*gi +: 8];
  end

  always_comb begin
    case (funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata_ext = {24'b0, shifted[7:0]};
      F3_HU:   rdata_ext = {16'b0, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the single memory port between instruction fetch and
// data load/store, one handshaked bus transaction at a time with timeout.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iIF_Req,
  input  logic [ADDR_W-1:0] iIF_Addr,
  output logic [31:0]       oIF_Data,
  output logic              oIF_Rdy,
  output logic              oIF_Err,
  input  logic              iD_Req,
  input  logic              iD_We,
  input  logic [2:0]        iD_Funct3,
  input  logic [ADDR_W-1:0] iD_Addr,
  input  logic [31:0]       iD_WData,
  output logic [31:0]       oD_RData,
  output logic              oD_Rdy,
  output logic              oD_Err,
  output logic              oMemReq,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [3:0]        oMemBE,
  output logic [31:0]       oMemWData,
  input  logic [31:0]       iMemRData,
  input  logic              iMemAck
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  arb_state_t        state_reg, state_next;
  logic              last_data_reg;
  logic              gnt_data_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [2:0]        f3_reg;
  logic              we_reg;
  logic [31:0]       wdata_reg;
  logic [7:0]        cnt_reg;
  logic              err_reg;
  logic [31:0]       if_data_reg;
  logic [31:0]       d_rdata_reg;

  logic              any_req, grant_data, req_illegal, timeout_hit, in_bus;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_f3;
  logic              sel_we;
  logic [31:0]       sel_wdata;
  logic [2:0]        al_f3;
  logic [1:0]        al_addr;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_rdata;
  logic              al_misalign;

  assign any_req    = iIF_Req | iD_Req;
  assign grant_data = iD_Req & (~iIF_Req | ~last_data_reg);
  // A fetch is steered through the lane logic as an aligned word load.
  assign sel_addr   = grant_data ? iD_Addr : iIF_Addr;
  assign sel_f3     = grant_data ? iD_Funct3 : F3_W;
  assign sel_we     = grant_data & iD_We;
  assign sel_wdata  = grant_data ? iD_WData : 32'b0;

  // The one lane aligner checks the incoming request in IDLE, the latched one later.
  assign al_f3   = (state_reg == ST_IDLE) ? sel_f3 : f3_reg;
  assign al_addr = (state_reg == ST_IDLE) ? sel_addr[1:0] : addr_reg[1:0];

  mem_lane_align u_align (
    .funct3    (al_f3),
    .addr_lo   (al_addr),
    .wdata     (wdata_reg),
    .mem_rdata (iMemRData),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .misalign  (al_misalign)
  );

  assign req_illegal = al_misalign | (grant_data & f3_illegal(sel_f3, sel_we));
  assign timeout_hit = (cnt_reg == TO_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (any_req) state_next = req_illegal ? ST_RESP : ST_BUS;
      ST_BUS:  if (iMemAck || timeout_hit) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_reg     <= ST_IDLE;
      last_data_reg <= 1'b1;
      gnt_data_reg  <= 1'b0;
      addr_reg      <= '0;
      f3_reg        <= 3'b0;
      we_reg        <= 1'b0;
      wdata_reg     <= 32'b0;
      cnt_reg       <= 8'd0;
      err_reg       <= 1'b0;
      if_data_reg   <= 32'b0;
      d_rdata_reg   <= 32'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= 8'd0;
          if (any_req) begin
            last_data_reg <= grant_data;
            gnt_data_reg  <= grant_data;
            addr_reg      <= sel_addr;
            f3_reg        <= sel_f3;
            we_reg        <= sel_we;
            wdata_reg     <= sel_wdata;
            err_reg       <= req_illegal;
            if (req_illegal) begin
              if (grant_data) d_rdata_reg <= 32'b0;
              else            if_data_reg <= 32'b0;
            end
          end
        end
        ST_BUS: begin
          cnt_reg <= cnt_reg + 8'd1;
          if (iMemAck || timeout_hit) begin
            err_reg <= ~iMemAck;
            if (gnt_data_reg) d_rdata_reg <= iMemAck ? al_rdata : 32'b0;
            else              if_data_reg <= iMemAck ? al_rdata : 32'b0;
          end
        end
        default: cnt_reg <= 8'd0;
      endcase
    end
  end

  assign in_bus    = (state_reg == ST_BUS);
  assign oMemReq   = in_bus;
  assign oMemWe    = in_bus & we_reg;
  assign oMemAddr  = in_bus ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign oMemBE    = in_bus ? al_be : 4'b0000;
  assign oMemWData = in_bus ? al_wdata : 32'b0;

  assign oIF_Rdy  = (state_reg == ST_RESP) & ~gnt_data_reg;
  assign oD_Rdy   = (state_reg == ST_RESP) & gnt_data_reg;
  assign oIF_Err  = oIF_Rdy & err_reg;
  assign oD_Err   = oD_Rdy & err_reg;
  assign oIF_Data = if_data_reg;
  assign oD_RData = d_rdata_reg;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch and data load/store.
- Arbitrates between the two requesters and sequences one bus transaction at a time with a request/ack handshake.
- Generates byte enables and write-data lane replication from funct3, and aligns and sign-/zero-extends read data.
- Flags misaligned addresses, illegal funct3 and bus timeouts. Sits between the multi-cycle control/datapath and the memory.

Parameters:
- ADDR_W, 32, address width (bits [1:0] select the byte lane)
- TIMEOUT, 255, maximum cycles to wait for iMemAck before aborting; 8-bit counter, legal range 1..255

Ports:
- iClk  in  1  clock
- nRst  in  1  asynchronous active-low reset
- iIF_Req  in  1  fetch request, held until oIF_Rdy
- iIF_Addr  in  ADDR_W  fetch address
- oIF_Data  out  32  fetched instruction word
- oIF_Rdy  out  1  one-cycle completion pulse for fetch
- oIF_Err  out  1  fetch error (misaligned or timeout), valid with oIF_Rdy
- iD_Req  in  1  data request, held until oD_Rdy
- iD_We  in  1  1 = store, 0 = load
- iD_Funct3  in  3  access size/sign (RV32I load/store funct3)
- iD_Addr  in  ADDR_W  data address
- iD_WData  in  32  store data, right-aligned
- oD_RData  out  32  load result, aligned and extended
- oD_Rdy  out  1  one-cycle completion pulse for data
- oD_Err  out  1  data error (misaligned, illegal funct3 or timeout), valid with oD_Rdy
- oMemReq  out  1  bus request, held until iMemAck
- oMemWe  out  1  bus write enable
- oMemAddr  out  ADDR_W  word-aligned bus address ([1:0] = 0)
- oMemBE  out  4  byte enables
- oMemWData  out  32  lane-replicated write data
- iMemRData  in  32  bus read data, valid with iMemAck
- iMemAck  in  1  one-cycle bus completion

Behaviour:
- Reset (nRst low, asynchronous): state IDLE; all outputs 0; last-grant flag = DATA, so fetch wins the first tie; timeout counter 0.
- Reset asserted mid-transaction aborts it immediately. No Rdy is issued for the aborted transaction.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - Samples iIF_Req and iD_Req.
  - Only one asserted: grant it.
  - Both asserted: round-robin, granting the requester opposite to the last-grant flag.
  - On grant: latch the requester's address, funct3, we and wdata; update the last-grant flag.
  - Check legality in the same cycle.
    - Illegal request: go to RESP with err = 1 and no bus cycle.
    - Legal request: go to BUS.
- Legality rules:
  - Fetch is illegal if addr[1:0] != 0.
  - Data is illegal if funct3 is in {011, 110, 111}, or on stores if funct3[2] = 1.
  - Data is illegal if a half access has addr[0] = 1, or a word access has addr[1:0] != 0.
- BUS:
  - oMemReq = 1; oMemAddr, oMemWe, oMemBE, oMemWData are driven from the latched values and stay stable until exit.
  - Timeout counter increments each cycle.
  - iMemAck: capture iMemRData, go to RESP with err = 0.
  - Counter reaches TIMEOUT with no ack: drop oMemReq, go to RESP with err = 1 and rdata = 0.
  - A late iMemAck arriving outside BUS is ignored.
- RESP:
  - Exactly one cycle; the granted requester's Rdy = 1, with Data/RData and Err registered; then IDLE.
  - The requester deasserts Req on the edge after it sees Rdy.
  - If a requester drops Req mid-transaction, the transaction still completes and Rdy still pulses.
- Latency: Req sampled in IDLE at cycle 0 → oMemReq high in cycle 1 → ack in cycle k ≥ 1 → Rdy in cycle k+1. Illegal request: Rdy in cycle 1.
- Byte enables:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << addr[1:0].
  - Word: 4'b1111.
  - Fetch: 4'b1111, we = 0.
- Write data:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Read data: shift iMemRData right by 8*addr[1:0], then extend.
  - LB: sign-extend from bit 7.
  - LH: sign-extend from bit 15.
  - LBU/LHU: zero-extend.
  - LW: unchanged.
- Between transactions the Rdy/Err outputs are 0; Data/RData hold their last value.

Decomposition:
- Shared package (riscv_pkg):
  - funct3 size constants: F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101.
  - Opcode constants used by control.
  - FSM state encoding for this block.
- One natural sub-module, mem_lane_align (combinational): funct3 plus addr → BE, replicated wdata, extracted and extended rdata, and misalign flag.

Test Plan:
- Fetch-only: IF_Addr = 0x100, ack after 2 cycles with RData = 0x00500093 → oIF_Rdy in cycle 3, oIF_Data = 0x00500093, oIF_Err = 0, oMemBE = 1111.
- Simultaneous iIF_Req and iD_Req after reset → fetch is granted first, then data. Repeat the tie → data first, then fetch (round-robin alternates).
- LB at addr 0x203 with RData = 0x80FF_FF7F → BE = 1000, oD_RData = 0xFFFFFF80. LHU at 0x202 with the same word → 0x000080FF.
- SB at 0x301 with wdata 0x12345678 → oMemBE = 0010, oMemWData = 0x78787878, oMemWe = 1, oMemAddr = 0x300.
- LW at 0x402 → no oMemReq, oD_Rdy = 1 with oD_Err = 1 in cycle 1. Fetch at 0x102 → oIF_Err = 1.
- Data request with no ack and TIMEOUT = 4 → oMemReq high for 4 cycles, then oD_Rdy = 1, oD_Err = 1. Assert nRst during BUS → all outputs 0 immediately and no Rdy.
